vga_scan_ctrl: RTL and testbench
================================

# vga_scan_ctrl

Raster sequencer for the 160x120, 4-bit-per-pixel color framebuffer. Runs standard 640x480@60 timing on the VGA pixel clock and scales each framebuffer pixel to a 4x4 block. Drives the framebuffer read coordinates and produces sync and display-enable outputs delayed to line up with the framebuffer's one-cycle registered read data. Also maintains a frame counter and an optional vertical-blank interrupt toward the core.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- i_clk, input, 1, VGA pixel clock (25 MHz); the only clock
- i_rst, input, 1, reset; synchronous, active-high
- i_enable, input, 1, scan-out enable
- i_irqAck, input, 1, clears the pending vblank IRQ (only with VGA_VBLANK_IRQ_EN)
- o_pxlX, output, 8, framebuffer column, 0..159
- o_pxlY, output, 8, framebuffer row, 0..119
- o_hsync, output, 1, horizontal sync, active low
- o_vsync, output, 1, vertical sync, active low
- o_de, output, 1, display enable, aligned with framebuffer read data
- o_frame, output, 16, count of completed visible frames
- o_vblankIrq, output, 1, level interrupt, pending vblank

## Operation
- Counters: hcnt 10 bit, range 0..H_TOTAL-1 (800). vcnt 10 bit, range 0..V_TOTAL-1 (525).
  - hcnt increments every RUN cycle.
  - At hcnt = H_TOTAL-1, hcnt wraps to 0 and vcnt increments.
  - vcnt wraps to 0 after V_TOTAL-1.
- State machine:
  - IDLE: counters held at 0; o_hsync = o_vsync = 1; o_de = 0.
  - IDLE -> RUN when i_enable = 1.
  - RUN -> IDLE when i_enable = 0 at any point. Counters clear on the next edge, so a re-enable always restarts at hcnt = vcnt = 0 (top-left of a frame).
- Coordinates, combinational from the counters:
  - o_pxlX = hcnt[9:2] while hcnt < H_VISIBLE, else 0.
  - o_pxlY = {1'b0, vcnt[8:2]} while vcnt < V_VISIBLE, else 0.
- Raw sync and enable, computed from the current counters:
  - hs_raw = !(hcnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]), i.e. low for 656..751.
  - vs_raw = !(vcnt in [490, 491]).
  - de_raw = (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE).
- Output alignment: hs_raw, vs_raw and de_raw are registered once to give o_hsync, o_vsync and o_de, matching the one-cycle framebuffer read latency.
- Frame counter:
  - o_frame increments by 1 on the cycle where hcnt wraps with vcnt = V_VISIBLE-1 (entering vblank).
  - Wraps modulo 2^16.
  - Does not advance in IDLE.

## Timing
- Reset values: hcnt = vcnt = 0, state IDLE, o_hsync = 1, o_vsync = 1, o_de = 0, o_frame = 0, o_vblankIrq = 0, o_pxlX = o_pxlY = 0.
- i_rst has priority over i_enable and i_irqAck.
- Latency:
  - o_pxlX and o_pxlY reflect the counters in the same cycle.
  - o_de, o_hsync and o_vsync lag the counters by exactly 1 cycle.
- First RUN cycle after i_enable rises: hcnt = 0, o_pxlX = 0, o_pxlY = 0. o_de rises on the following cycle.
- Line period: 800 cycles. Frame period: 420000 cycles.
- Each framebuffer pixel is presented for 4 consecutive cycles on each of 4 consecutive lines.
- Dropping i_enable mid-line: the next cycle is IDLE with counters 0. o_de and the syncs take their inactive values one cycle after that, via the output register.

## Configuration
- Macro: VGA_VBLANK_IRQ_EN.
- Defined:
  - A pending flag sets on the o_frame increment event.
  - The flag clears on i_irqAck = 1.
  - If set and ack occur in the same cycle, set wins and the flag stays 1.
  - o_vblankIrq = flag.
  - The flag is cleared on reset and is held (not cleared) in IDLE.
- Undefined: o_vblankIrq tied to 0; i_irqAck ignored; no flag register.

## Test plan
- Reset, then i_enable = 1 -> o_hsync = 1, o_vsync = 1, o_de = 0 during reset. o_de = 1 on the 2nd cycle after enable. o_pxlX = 0, 0, 0, 0, 1 over the first 5 RUN cycles.
- Run one line -> o_de high for 640 cycles. o_hsync low for exactly 96 cycles, starting 1 cycle after hcnt = 656. Next line starts 800 cycles after the first.
- Run to line 4 -> o_pxlY changes 0 -> 1 at vcnt = 4. At vcnt = 476, o_pxlY = 119. During vcnt 480..524, o_pxlY = 0 and o_de = 0.
- Run one full frame -> vsync low for 1600 cycles. o_frame 0 -> 1 at the hcnt wrap of line 479. Counters return to 0 after 420000 cycles.
- Drop i_enable at hcnt = 300, vcnt = 50, then re-enable -> counters restart at 0,0 and o_frame is unchanged. Separately, preload o_frame to 0xFFFF -> it wraps to 0x0000 at the next vblank.
- With VGA_VBLANK_IRQ_EN: o_vblankIrq rises at the vblank entry and holds until i_irqAck. Asserting i_irqAck on the same cycle as the next set event leaves o_vblankIrq = 1.

Source files
------------

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: raster sequencer for a 160x120 4bpp framebuffer shown on
// 640x480@60 VGA timing with 4x4 pixel replication.
//
// Framebuffer read coordinates come straight from the raster counters. Sync
// and display-enable are registered once, so they line up with the
// framebuffer's registered read data.
//
// Optional feature macro: VGA_VBLANK_IRQ_EN
//   defined   - a pending vblank interrupt flag is set on each visible-frame
//               completion and cleared by i_irqAck (a set wins over an ack).
//   undefined - o_vblankIrq is tied low and i_irqAck is ignored.
module vga_scan_ctrl #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_irqAck,
  output logic [7:0]  o_pxlX,
  output logic [7:0]  o_pxlY,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [15:0] o_frame,
  output logic        o_vblankIrq
);

  // Raster geometry, folded into 10-bit constants to match the counters.
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;

  // Advance strobe: high only on RUN cycles that keep running, so a cycle in
  // which i_enable drops never wraps a line or counts a frame.
  logic        run_adv;
  logic        h_last;
  logic        v_last;
  logic        frame_tick;

  logic        in_run;
  logic        h_vis;
  logic        v_vis;
  logic        hs_raw;
  logic        vs_raw;
  logic        de_raw;

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q,    de_d;
  logic [15:0] frame_q, frame_d;

  assign h_last = (hcnt_q == H_LAST);
  assign v_last = (vcnt_q == V_LAST);

  // State register and raster counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  // Next state and counter stepping. IDLE forces the counters to zero so a
  // re-enable always starts at the top-left of a frame.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    run_adv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (i_enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
          hcnt_d  = '0;
          vcnt_d  = '0;
        end else begin
          run_adv = 1'b1;
          if (h_last) begin
            hcnt_d = '0;
            vcnt_d = v_last ? 10'd0 : vcnt_q + 10'd1;
          end else begin
            hcnt_d = hcnt_q + 10'd1;
          end
        end
      end
    endcase
  end

  // Framebuffer coordinates: divide by 4 for the 4x4 replication and park at
  // zero outside the visible area.
  always_comb begin
    h_vis  = (hcnt_q < H_VIS);
    v_vis  = (vcnt_q < V_VIS);
    o_pxlX = h_vis ? hcnt_q[9:2] : 8'd0;
    o_pxlY = v_vis ? {1'b0, vcnt_q[8:2]} : 8'd0;
  end

  // Raw sync/enable from the current counters; everything inactive in IDLE.
  always_comb begin
    in_run = (state_q == ST_RUN);
    hs_raw = !(in_run && (hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
    vs_raw = !(in_run && (vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
    de_raw = in_run && h_vis && v_vis;
  end

  // A visible frame completes when the last visible line wraps.
  assign frame_tick = run_adv && h_last && (vcnt_q == V_VIS_LAST);

  // Next values for the aligned outputs and the frame counter.
  always_comb begin
    hsync_d = hs_raw;
    vsync_d = vs_raw;
    de_d    = de_raw;
    frame_d = frame_tick ? frame_q + 16'd1 : frame_q;
  end

  // One-cycle output alignment register and frame counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      frame_q <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      frame_q <= frame_d;
    end
  end

  assign o_hsync = hsync_q;
  assign o_vsync = vsync_q;
  assign o_de    = de_q;
  assign o_frame = frame_q;

`ifdef VGA_VBLANK_IRQ_EN
  logic irq_q, irq_d;

  // Pending flag: a new vblank wins over a simultaneous acknowledge. Leaving
  // RUN does not touch it, so a pending event survives a scan-out pause.
  always_comb begin
    irq_d = irq_q;
    if (frame_tick) begin
      irq_d = 1'b1;
    end else if (i_irqAck) begin
      irq_d = 1'b0;
    end
  end

  // Pending vblank flag register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign o_vblankIrq = irq_q;
`else
  // No interrupt logic in this build; the acknowledge input is a no-op.
  logic unused_irq_ack;
  assign unused_irq_ack = i_irqAck;
  assign o_vblankIrq    = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: randomized self-checking bench for vga_scan_ctrl.
// Two instances share the stimulus: one with the standard 640x480 timing and
// one with a tiny raster so many complete frames fit in a short run. Both are
// compared every cycle against a model that derives the raster position from
// the number of cycles elapsed since scan-out started.
module tb_vga_scan_ctrl;

  // Instance 0: default geometry. Instance 1: compact geometry.
  localparam int P_HV[2] = '{640, 16};
  localparam int P_HF[2] = '{16, 2};
  localparam int P_HS[2] = '{96, 3};
  localparam int P_HB[2] = '{48, 3};
  localparam int P_VV[2] = '{480, 12};
  localparam int P_VF[2] = '{10, 1};
  localparam int P_VS[2] = '{2, 2};
  localparam int P_VB[2] = '{33, 1};

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic ack;

  logic [7:0]  d_pxlX, d_pxlY, s_pxlX, s_pxlY;
  logic        d_hs, d_vs, d_de, s_hs, s_vs, s_de;
  logic [15:0] d_frame, s_frame;
  logic        d_irq, s_irq;

  always #5 clk = ~clk;

  vga_scan_ctrl dut_d (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_irqAck(ack),
    .o_pxlX(d_pxlX), .o_pxlY(d_pxlY), .o_hsync(d_hs), .o_vsync(d_vs),
    .o_de(d_de), .o_frame(d_frame), .o_vblankIrq(d_irq)
  );

  vga_scan_ctrl #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_s (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_irqAck(ack),
    .o_pxlX(s_pxlX), .o_pxlY(s_pxlY), .o_hsync(s_hs), .o_vsync(s_vs),
    .o_de(s_de), .o_frame(s_frame), .o_vblankIrq(s_irq)
  );

  // Reference model state per instance.
  bit          m_run[2];
  int          m_t[2];
  bit          m_hs[2];
  bit          m_vs[2];
  bit          m_de[2];
  logic [15:0] m_frame[2];
  bit          m_irq[2];

  int  n_vec  = 0;
  int  n_miss = 0;
  int  cyc    = 0;
  bit  checking = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at the edge.
  task automatic model_step(input int k);
    int ht, vt, h, v;
    bit tick;
    ht = P_HV[k] + P_HF[k] + P_HS[k] + P_HB[k];
    vt = P_VV[k] + P_VF[k] + P_VS[k] + P_VB[k];
    h  = m_run[k] ? (m_t[k] % ht) : 0;
    v  = m_run[k] ? ((m_t[k] / ht) % vt) : 0;
    if (rst) begin
      m_run[k]   = 1'b0;
      m_t[k]     = 0;
      m_hs[k]    = 1'b1;
      m_vs[k]    = 1'b1;
      m_de[k]    = 1'b0;
      m_frame[k] = 16'd0;
      m_irq[k]   = 1'b0;
    end else begin
      m_hs[k] = !(m_run[k] && h >= P_HV[k] + P_HF[k] && h < P_HV[k] + P_HF[k] + P_HS[k]);
      m_vs[k] = !(m_run[k] && v >= P_VV[k] + P_VF[k] && v < P_VV[k] + P_VF[k] + P_VS[k]);
      m_de[k] = m_run[k] && h < P_HV[k] && v < P_VV[k];
      tick = m_run[k] && en && h == ht - 1 && v == P_VV[k] - 1;
      if (tick) m_frame[k] = m_frame[k] + 16'd1;
`ifdef VGA_VBLANK_IRQ_EN
      if (tick) m_irq[k] = 1'b1;
      else if (ack) m_irq[k] = 1'b0;
`endif
      if (m_run[k] && en) begin
        m_t[k] = m_t[k] + 1;
      end else begin
        m_run[k] = en;
        m_t[k]   = 0;
      end
    end
  endtask

  // Compare one instance's outputs with the model for the current cycle.
  task automatic check_inst(input int k, input logic [7:0] px, input logic [7:0] py,
                            input logic hs, input logic vs, input logic de,
                            input logic [15:0] fr, input logic irq);
    int ht, vt, h, v;
    string p;
    p  = (k == 0) ? "def" : "small";
    ht = P_HV[k] + P_HF[k] + P_HS[k] + P_HB[k];
    vt = P_VV[k] + P_VF[k] + P_VS[k] + P_VB[k];
    h  = m_run[k] ? (m_t[k] % ht) : 0;
    v  = m_run[k] ? ((m_t[k] / ht) % vt) : 0;
    check_val({p, ".pxlX"},  32'(px),  32'((h < P_HV[k]) ? h / 4 : 0));
    check_val({p, ".pxlY"},  32'(py),  32'((v < P_VV[k]) ? v / 4 : 0));
    check_val({p, ".hsync"}, 32'(hs),  32'(m_hs[k]));
    check_val({p, ".vsync"}, 32'(vs),  32'(m_vs[k]));
    check_val({p, ".de"},    32'(de),  32'(m_de[k]));
    check_val({p, ".frame"}, 32'(fr),  32'(m_frame[k]));
    check_val({p, ".irq"},   32'(irq), 32'(m_irq[k]));
  endtask

  // Model advances on the active edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  // Outputs sampled on the opposite edge.
  always @(negedge clk) begin
    cyc++;
    if (checking) begin
      check_inst(0, d_pxlX, d_pxlY, d_hs, d_vs, d_de, d_frame, d_irq);
      check_inst(1, s_pxlX, s_pxlY, s_hs, s_vs, s_de, s_frame, s_irq);
    end
  end

  initial begin
    int c;
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 1'b0; m_t[k] = 0; m_hs[k] = 1'b1; m_vs[k] = 1'b1;
      m_de[k] = 1'b0; m_frame[k] = 16'd0; m_irq[k] = 1'b0;
    end
    rst = 1'b1;
    en  = 1'b0;
    ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checking = 1'b1;
    $display("txn reset: held 2 cycles");

    // Enable and run until the default raster sits at hcnt=300, vcnt=50.
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    c = 0;
    while (!(m_run[0] && m_t[0] == 50 * 800 + 300) && c < 60000) begin
      @(negedge clk);
      ack = ($urandom % 64) == 0;
      c++;
    end
    if (c >= 60000) check_val("reach_h300_v50", 32'(m_t[0]), 32'(50 * 800 + 300));
    $display("txn run: %0d cycles, small-raster frames=%0d", c, m_frame[1]);

    // Drop scan-out mid-line, pause briefly, then restart at the frame origin.
    en = 1'b0;
    repeat (1 + $urandom % 4) @(negedge clk);
    en = 1'b1;
    repeat (2000) begin
      @(negedge clk);
      ack = ($urandom % 64) == 0;
    end
    $display("txn restart: 2000 cycles after re-enable");

    // Randomized enable drops, acknowledges and occasional resets.
    repeat (8000) begin
      @(negedge clk);
      en  = ($urandom % 1500) != 0;
      ack = ($urandom % 8) == 0;
      rst = ($urandom % 3000) == 0;
    end
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);
    $display("txn random: 8000 cycles");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
